// File: rtl/minterm_pkg.sv
// Shared types and defaults for the minterm sweeper: FSM state encoding and
// default sizing for the input-combination vector and settle time.
package minterm_pkg;

  localparam int N_IN_DEF          = 3;
  localparam int SETTLE_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/minterm_settle_timer.sv
// Settle counter: cleared by load, advanced by tick; expire flags the last
// settle cycle so the sweeper can move on to sampling.
module minterm_settle_timer
  import minterm_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic expire
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= 8'd0;
    end else if (tick) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expire = (cnt == 8'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/minterm_sweeper.sv
// Walks every input combination, lets both function implementations settle,
// then records implementation A's truth table and where A and B disagree.
module minterm_sweeper
  import minterm_pkg::*;
#(
  parameter int N_IN          = N_IN_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      abc,
  input  logic                 y_a,
  input  logic                 y_b,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   mask_a,
  output logic [2**N_IN-1:0]   mismatch_mask,
  output logic                 mismatch
);

  state_t state;
  logic   last_combo;
  logic   timer_load;
  logic   timer_tick;
  logic   settle_expire;

  assign last_combo = (abc == {N_IN{1'b1}});

  // The counter restarts on every new combination; it never needs clearing
  // after the final sample because the next accepted start reloads it.
  assign timer_load = ((state == IDLE) && start) ||
                      ((state == SAMPLE) && !last_combo);
  assign timer_tick = (state == SETTLE);

  minterm_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .tick  (timer_tick),
    .expire(settle_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      abc           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mask_a        <= '0;
      mismatch_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          abc  <= '0;
          if (start) begin
            mask_a        <= '0;
            mismatch_mask <= '0;
            busy          <= 1'b1;
            state         <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_expire) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          mask_a[abc]        <= y_a;
          mismatch_mask[abc] <= y_a ^ y_b;
          if (last_combo) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            abc   <= abc + N_IN'(1);
            state <= SETTLE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mismatch = |mismatch_mask;

endmodule

// File: tb/tb_minterm_sweeper.sv
// Scoreboard bench for minterm_sweeper: expected sweep results are queued at
// start and checked against the DUT when done pulses.
module tb_minterm_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] abc;
  logic       y_a;
  logic       y_b;
  logic       busy;
  logic       done;
  logic [7:0] mask_a;
  logic [7:0] mismatch_mask;
  logic       mismatch;

  logic       start1;
  logic [2:0] abc1;
  logic       y1;
  logic       busy1;
  logic       done1;
  logic [7:0] mask_a1;
  logic [7:0] mismatch_mask1;
  logic       mismatch1;

  always #5 clk = ~clk;

  minterm_sweeper dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abc          (abc),
    .y_a          (y_a),
    .y_b          (y_b),
    .busy         (busy),
    .done         (done),
    .mask_a       (mask_a),
    .mismatch_mask(mismatch_mask),
    .mismatch     (mismatch)
  );

  minterm_sweeper #(
    .N_IN         (3),
    .SETTLE_CYCLES(1)
  ) dut1 (
    .clk          (clk),
    .rst          (rst),
    .start        (start1),
    .abc          (abc1),
    .y_a          (y1),
    .y_b          (y1),
    .busy         (busy1),
    .done         (done1),
    .mask_a       (mask_a1),
    .mismatch_mask(mismatch_mask1),
    .mismatch     (mismatch1)
  );

  typedef struct {
    int         acc;
    logic [7:0] ma;
    logic [7:0] mm;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         mode     = 0;
  logic [7:0] tab_a    = 8'h00;
  logic [7:0] tab_b    = 8'h00;
  logic       done_q   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Function-under-test responses; mode 2 corrupts y_b in every non-sample cycle.
  always @(negedge clk) begin
    int j;
    j = (sb.size() > 0) ? (cyc - sb[0].acc) : 0;
    case (mode)
      0: begin y_a = abc[0]; y_b = abc[0]; end
      1: begin y_a = abc[0]; y_b = abc[0] ^ (abc == 3'd6); end
      2: begin y_a = abc[1]; y_b = abc[1] ^ ((j % 3) != 2); end
      default: begin y_a = tab_a[abc]; y_b = tab_b[abc]; end
    endcase
  end

  always @(negedge clk) begin
    int   j;
    exp_t e;
    if (!rst && sb.size() > 0) begin
      j = cyc - sb[0].acc;
      if (j >= 0 && j < 24) begin
        check_eq("busy_in_sweep", busy, 1'b1);
        if ((j % 3) == 2) check_eq("abc_order", abc, j / 3);
      end
    end
    if (done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", done, 1'b0);
      end else begin
        e = sb.pop_front();
        check_eq("done_latency", cyc - e.acc, 24);
        check_eq("mask_a", mask_a, e.ma);
        check_eq("mismatch_mask", mismatch_mask, e.mm);
        check_eq("mismatch", mismatch, e.mm != 8'h00);
        check_eq("busy_in_done", busy, 1'b0);
      end
    end
    if (done_q) begin
      check_eq("done_width", done, 1'b0);
      check_eq("busy_after_done", busy, 1'b0);
    end
    done_q = done;
  end

  task automatic push_exp(input int acc, input logic [7:0] ma, input logic [7:0] mm);
    exp_t e;
    e.acc = acc;
    e.ma  = ma;
    e.mm  = mm;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      check_eq("sweep_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic sweep(input int m, input logic [7:0] ma, input logic [7:0] mm, input bit poke);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    push_exp(cyc + 1, ma, mm);
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      repeat (7) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_drain();
  endtask

  initial begin
    int acc;
    int n;
    rst    = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    y1     = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_abc", abc, 3'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_mask_a", mask_a, 8'h00);
    check_eq("rst_mm", mismatch_mask, 8'h00);
    check_eq("rst_mismatch", mismatch, 1'b0);
    rst = 1'b0;

    sweep(0, 8'hAA, 8'h00, 1'b0);
    sweep(1, 8'hAA, 8'h40, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("hold_mask_a", mask_a, 8'hAA);
    check_eq("hold_mm", mismatch_mask, 8'h40);
    check_eq("hold_mismatch", mismatch, 1'b1);

    sweep(2, 8'hCC, 8'h00, 1'b0);
    tab_a = 8'h5C;
    tab_b = 8'h59;
    sweep(3, 8'h5C, 8'h05, 1'b0);
    tab_a = 8'($urandom);
    tab_b = 8'($urandom);
    sweep(3, tab_a, tab_a ^ tab_b, 1'b0);

    // start held high across two back-to-back sweeps
    @(negedge clk);
    mode  = 0;
    start = 1'b1;
    acc   = cyc + 1;
    push_exp(acc, 8'hAA, 8'h00);
    push_exp(acc + 26, 8'hAA, 8'h00);
    wait_drain();
    start = 1'b0;
    repeat (4) @(negedge clk);

    // reset in the middle of a sweep
    @(negedge clk);
    mode  = 0;
    start = 1'b1;
    push_exp(cyc + 1, 8'hAA, 8'h00);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (abc != 3'd4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_abc4", abc, 3'd4);
    check_eq("pre_rst_mask_a", mask_a, 8'h0A);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_eq("midrst_abc", abc, 3'd0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_mask_a", mask_a, 8'h00);
    check_eq("midrst_mm", mismatch_mask, 8'h00);
    check_eq("midrst_done", done, 1'b0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("idle_after_rst", busy, 1'b0);

    // short-settle instance
    @(negedge clk);
    start1 = 1'b1;
    acc    = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("s1_done_seen", done1, 1'b1);
    check_eq("s1_latency", cyc - acc, 16);
    check_eq("s1_mask_a", mask_a1, 8'hFF);
    check_eq("s1_mm", mismatch_mask1, 8'h00);
    check_eq("s1_mismatch", mismatch1, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
